// File: rtl/mult_div_unit_if.sv
// Datapath-side bundle for the iterative multiply/divide unit.
// The master is the decoder/datapath; the slave is the unit itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, one bit per cycle.
// Define MDU_SIGNED_OPS_EN to enable signed MULT/DIV; otherwise all ops are unsigned.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [5:0]             count_reg;
  logic [2*WIDTH-1:0]     acc_reg;
  logic [2*WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]       operand_reg;
  logic [WIDTH-1:0]       dividend_reg;
  logic                   is_div_reg;
  logic                   div_zero_reg;
  logic [WIDTH-1:0]       hi_reg;
  logic [WIDTH-1:0]       lo_reg;

  logic                   start_accept;
  logic                   last_iter;
  logic                   is_div;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_trial;
  logic [WIDTH-1:0]       res_hi;
  logic [WIDTH-1:0]       res_lo;

  assign is_div       = bus.op[1];
  assign start_accept = bus.start && (state_reg != RUN);
  assign last_iter    = (state_reg == RUN) && (count_reg == 6'(WIDTH - 1));

`ifdef MDU_SIGNED_OPS_EN
  logic a_neg, b_neg;
  logic neg_q_reg, neg_r_reg;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = a_neg ? -bus.a : bus.a;
  assign mag_b = b_neg ? -bus.b : bus.b;

  // Product sign and quotient sign share one flag; remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (start_accept) begin
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
    end
  end
`else
  logic unused_op_sign;

  assign mag_a          = bus.a;
  assign mag_b          = bus.b;
  assign unused_op_sign = bus.op[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count_reg == 6'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply: shift-add with the multiplier in the low half of acc.
  // Divide: restoring, remainder in the upper half, quotient shifting into the lower half.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand_reg};
    if (is_div_reg) begin
      if (div_trial[WIDTH]) begin
        acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // Final HI/LO image computed from the last iteration's accumulator.
  always_comb begin
    res_hi = acc_next[2*WIDTH-1:WIDTH];
    res_lo = acc_next[WIDTH-1:0];
`ifdef MDU_SIGNED_OPS_EN
    if (is_div_reg) begin
      if (neg_q_reg) res_lo = -acc_next[WIDTH-1:0];
      if (neg_r_reg) res_hi = -acc_next[2*WIDTH-1:WIDTH];
    end else if (neg_q_reg) begin
      {res_hi, res_lo} = -acc_next;
    end
`endif
    if (is_div_reg && div_zero_reg) begin
      res_lo = '1;
      res_hi = dividend_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      dividend_reg <= '0;
      is_div_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (start_accept) begin
      count_reg    <= '0;
      acc_reg      <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      operand_reg  <= is_div ? mag_b : mag_a;
      dividend_reg <= bus.a;
      is_div_reg   <= is_div;
      div_zero_reg <= (bus.b == '0);
    end else if (state_reg == RUN) begin
      count_reg <= count_reg + 6'd1;
      acc_reg   <= acc_next;
    end
  end

  // MTHI/MTLO land even alongside an accepted start; the result overwrites them later.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (last_iter) begin
      hi_reg <= res_hi;
      lo_reg <= res_lo;
    end else if (state_reg != RUN) begin
      if (bus.hi_we) hi_reg <= bus.wdata;
      if (bus.lo_we) lo_reg <= bus.wdata;
    end
  end

  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      check("done without busy", {31'd0, bus.busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected done pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, " hi"}, bus.hi, e.hi);
        check({e.name, " lo"}, bus.lo, e.lo);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  // Waits for done, counting busy cycles; exp_busy < 0 skips the busy-count check.
  task automatic wait_done(input string name, input int exp_busy);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({name, " done seen"}, {31'd0, seen}, 32'd1);
    if (exp_busy >= 0) check({name, " busy cycles"}, busy_n, exp_busy);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    push_exp(name, exp_hi, exp_lo);
    issue(op, a, b);
    wait_done(name, 32);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);

    run_op("MULTU ffffffff*ffffffff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
`ifdef MDU_SIGNED_OPS_EN
    run_op("MULT -3*7",          2'b01, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("DIV -7/2",           2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIV 7/-2",           2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("DIV 80000000/-1",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("DIV -9/0",           2'b11, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF);
`else
    run_op("MULT -3*7",          2'b01, 32'hFFFF_FFFD, 32'd7,        32'h0000_0006, 32'hFFFF_FFEB);
    run_op("DIV -7/2",           2'b11, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
    run_op("DIV 7/-2",           2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000);
    run_op("DIV 80000000/-1",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    run_op("DIV -9/0",           2'b11, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF);
`endif
    run_op("DIVU 100/0",         2'b10, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF);
    run_op("DIVU 1000/7",        2'b10, 32'd1000,      32'd7,        32'd6,         32'd142);

    // Reset in the middle of RUN: no done, everything back to reset values.
    issue(2'b00, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort hi", bus.hi, 32'h0);
    check("abort lo", bus.lo, 32'h0);
    repeat (40) @(negedge clk);
    run_op("MULTU 7*9 after abort", 2'b00, 32'd7, 32'd9, 32'd0, 32'd63);

    // MTHI while idle, then MTLO during RUN is dropped.
    @(posedge clk);
    #1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    @(negedge clk);
    check("MTHI idle hi", bus.hi, 32'h0000_1234);
    push_exp("MULTU 5*6 with MTLO in RUN", 32'd0, 32'd30);
    issue(2'b00, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5678;
    @(posedge clk);
    #1 bus.lo_we = 1'b0;
    @(negedge clk);
    check("MTLO in RUN lo", bus.lo, 32'd63);
    check("hi held in RUN", bus.hi, 32'h0000_1234);
    wait_done("MULTU 5*6 with MTLO in RUN", -1);

    // Back-to-back: second start presented during the DONE cycle.
    push_exp("DIVU 13/5", 32'd3, 32'd2);
    issue(2'b10, 32'd13, 32'd5);
    wait_done("DIVU 13/5", 32);
    push_exp("MULTU 3*4 back-to-back", 32'd0, 32'd12);
    bus.op    = 2'b00;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("MULTU 3*4 back-to-back", 32);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
